// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared types and constants for the HUB-75 receive path.
//   k_default_width / k_default_height : default panel geometry
//   k_half_height                      : row offset of the lower RGB lane
//   k_pixels_per_latch                 : beats streamed per accepted latch
//   XIndex, YIndex, RowAddr, ColCount  : index types for the default geometry
//   Rgb, PixelPair                     : 3-bit pixel, {upper, lower} pixel pair
//   RxState                            : receiver output FSM states
`timescale 1ns/1ps
package hub75_pkg;

  localparam int k_default_width    = 64;
  localparam int k_default_height   = 64;
  localparam int k_half_height      = k_default_height / 2;
  localparam int k_pixels_per_latch = 2 * k_default_width;

  typedef logic [$clog2(k_default_width)-1:0]     XIndex;
  typedef logic [$clog2(k_default_height)-1:0]    YIndex;
  typedef logic [$clog2(k_half_height)-1:0]       RowAddr;
  typedef logic [$clog2(k_default_width+2)-1:0]   ColCount;
  typedef logic [2:0]                             Rgb;

  // One shifted column: upper-lane {r1,g1,b1} in [5:3], lower-lane {r2,g2,b2} in [2:0].
  typedef logic [5:0] PixelPair;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } RxState;

  // Select the upper or lower lane of a stored column.
  function automatic Rgb pick_half(input PixelPair p, input logic lower);
    return lower ? p[2:0] : p[5:3];
  endfunction

endpackage

// File: rtl/hub75_input_sync.sv
// hub75_input_sync
// Per-bit two-flop synchronizer followed by a rising-edge detector.
// The level output is delayed by one extra stage so that it lines up with the
// registered rise strobe: data sampled alongside a strobe belongs to it.
// Ports:
//   clock  in   system clock
//   reset  in   asynchronous active-low reset (all stages clear to 0)
//   d      in   [WIDTH] asynchronous inputs
//   level  out  [WIDTH] synchronized level, aligned with rise
//   rise   out  [WIDTH] one-cycle pulse per synchronized 0->1 transition
`timescale 1ns/1ps
module hub75_input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;
      logic rise_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
          rise_reg <= 1'b0;
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
          rise_reg <= sync_reg & ~prev_reg;
        end
      end

      assign level[gi] = prev_reg;
      assign rise[gi]  = rise_reg;
    end
  endgenerate

endmodule

// File: rtl/hub75_receiver.sv
// hub75_receiver
// Receive-side HUB-75 endpoint. Samples the panel bus in the system clock
// domain, rebuilds each latched row pair in a capture buffer, copies it to an
// output buffer on a good latch and streams 2*k_width pixels over valid/ready
// (upper row first, then the lower row k_height/2 further down).
// Optional feature macro: HUB75_RX_OE_CHECK_EN enables blank_error (latch
// while the panel is not blanked). Without it hub_oe is ignored.
// Ports:
//   clock, reset            system clock, asynchronous active-low reset
//   hub_clk, hub_lat        shift clock and latch (asynchronous)
//   hub_oe                  output enable, active-low
//   hub_r1/g1/b1, r2/g2/b2  upper / lower lane pixel bits
//   hub_addr                row-pair address
//   out_valid/out_ready     pixel stream handshake
//   out_x, out_y, out_rgb   pixel column, row, {r,g,b}
//   line_error              pulse: latch with column count != k_width
//   drop                    pulse: good row discarded, output still busy
//   blank_error             pulse: latch while hub_oe low (feature macro only)
`timescale 1ns/1ps
module hub75_receiver
  import hub75_pkg::*;
#(
  parameter int k_width  = k_default_width,
  parameter int k_height = k_default_height
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          hub_clk,
  input  logic                          hub_lat,
  input  logic                          hub_oe,
  input  logic                          hub_r1,
  input  logic                          hub_g1,
  input  logic                          hub_b1,
  input  logic                          hub_r2,
  input  logic                          hub_g2,
  input  logic                          hub_b2,
  input  logic [$clog2(k_height/2)-1:0] hub_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(k_width)-1:0]    out_x,
  output logic [$clog2(k_height)-1:0]   out_y,
  output logic [2:0]                    out_rgb,
  output logic                          line_error,
  output logic                          drop,
  output logic                          blank_error
);

  localparam int k_x_bits     = $clog2(k_width);
  localparam int k_addr_bits  = $clog2(k_height / 2);
  localparam int k_count_bits = $clog2(k_width + 2);
  localparam int k_bus_bits   = 6 + k_addr_bits;
  localparam logic [k_count_bits-1:0] k_full_count = k_count_bits'(k_width);
  localparam logic [k_count_bits-1:0] k_sat_count  = k_count_bits'(k_width + 1);

  // ---------------------------------------------------------------------------
  // Input synchronization
  // ---------------------------------------------------------------------------
  logic [1:0] strobe_level_unused;
  logic [1:0] strobe_rise;
  logic       shift_stb;
  logic       latch_stb;

  hub75_input_sync #(.WIDTH(2)) u_strobe_sync (
    .clock (clock),
    .reset (reset),
    .d     ({hub_clk, hub_lat}),
    .level (strobe_level_unused),
    .rise  (strobe_rise)
  );

  assign shift_stb = strobe_rise[1];
  assign latch_stb = strobe_rise[0];

  logic [k_bus_bits-1:0]  bus_level;
  logic [k_bus_bits-1:0]  bus_rise_unused;
  PixelPair               pix_in;
  logic [k_addr_bits-1:0] addr_in;

  hub75_input_sync #(.WIDTH(k_bus_bits)) u_bus_sync (
    .clock (clock),
    .reset (reset),
    .d     ({hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2, hub_addr}),
    .level (bus_level),
    .rise  (bus_rise_unused)
  );

  assign pix_in  = bus_level[k_bus_bits-1 -: 6];
  assign addr_in = bus_level[k_addr_bits-1:0];

  logic blank_hit;

`ifdef HUB75_RX_OE_CHECK_EN
  logic oe_level;
  logic oe_rise_unused;

  hub75_input_sync #(.WIDTH(1)) u_oe_sync (
    .clock (clock),
    .reset (reset),
    .d     (hub_oe),
    .level (oe_level),
    .rise  (oe_rise_unused)
  );

  // Same sync depth as the latch strobe, so oe_level is the value at the latch.
  assign blank_hit = latch_stb && !oe_level;
`else
  logic oe_unused;
  assign oe_unused = hub_oe;
  assign blank_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Column counting and capture
  // ---------------------------------------------------------------------------
  logic [k_count_bits-1:0] col_count_reg;
  logic [k_count_bits-1:0] count_shifted;
  logic                    shift_we;
  logic [k_x_bits-1:0]     wr_x;
  logic                    row_ok;
  logic                    accept;
  RxState                  state_reg;
  RxState                  state_next;

  // The latch sees the count after a same-cycle shift has been applied.
  always_comb begin
    count_shifted = col_count_reg;
    if (shift_stb && (col_count_reg != k_sat_count)) begin
      count_shifted = col_count_reg + 1'b1;
    end
  end

  // Overlong lines stop writing once the row is full.
  assign shift_we = shift_stb && (col_count_reg < k_full_count);
  // k_width is a power of two, so k_width-1-col is the bitwise complement.
  assign wr_x     = ~col_count_reg[k_x_bits-1:0];
  assign row_ok   = latch_stb && (count_shifted == k_full_count);
  assign accept   = row_ok && (state_reg == ST_IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_count_reg <= '0;
    end else if (latch_stb) begin
      col_count_reg <= '0;
    end else begin
      col_count_reg <= count_shifted;
    end
  end

  PixelPair cap_buf [k_width];
  PixelPair out_buf [k_width];

  // Capture keeps running while the output buffer is being streamed. A same-cycle
  // shift is forwarded into the copy so the latched row includes it.
  always_ff @(posedge clock) begin
    if (shift_we) begin
      cap_buf[wr_x] <= pix_in;
    end
    if (accept) begin
      out_buf <= cap_buf;
      if (shift_we) begin
        out_buf[wr_x] <= pix_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  logic                   fire;
  logic                   last_beat;
  logic [k_x_bits-1:0]    x_reg;
  logic                   half_reg;
  logic [k_addr_bits-1:0] row_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign last_beat = half_reg && (&x_reg);

  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_beat) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign fire = out_valid && out_ready;

  // x wraps naturally at k_width; half flips back to the upper row after the
  // final beat so the position is already reset for the next row pair.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_reg    <= '0;
      half_reg <= 1'b0;
      row_reg  <= '0;
    end else if (accept) begin
      x_reg    <= '0;
      half_reg <= 1'b0;
      row_reg  <= addr_in;
    end else if (fire) begin
      x_reg <= x_reg + 1'b1;
      if (&x_reg) begin
        half_reg <= ~half_reg;
      end
    end
  end

  PixelPair out_pix;
  assign out_pix = out_buf[x_reg];

  assign out_x   = x_reg;
  // Lower row lives k_height/2 further down: the half bit is the y MSB.
  assign out_y   = {half_reg, row_reg};
  assign out_rgb = out_valid ? pick_half(out_pix, half_reg) : 3'b000;

  // ---------------------------------------------------------------------------
  // Status pulses
  // ---------------------------------------------------------------------------
  logic line_error_reg;
  logic drop_reg;
  logic blank_error_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      line_error_reg  <= 1'b0;
      drop_reg        <= 1'b0;
      blank_error_reg <= 1'b0;
    end else begin
      line_error_reg  <= latch_stb && (count_shifted != k_full_count);
      drop_reg        <= row_ok && (state_reg == ST_EMIT);
      blank_error_reg <= blank_hit;
    end
  end

  assign line_error  = line_error_reg;
  assign drop        = drop_reg;
  assign blank_error = blank_error_reg;

endmodule

// File: tb/tb_hub75_receiver.sv
`timescale 1ns/1ps
module tb_hub75_receiver;
  import hub75_pkg::*;

  localparam int W  = k_default_width;
  localparam int H  = k_default_height;
  localparam int AW = $clog2(H / 2);

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] rgb;
  } beat_t;

  logic                      clock = 1'b0;
  logic                      reset = 1'b0;
  logic                      hub_clk = 1'b0, hub_lat = 1'b0, hub_oe = 1'b1;
  logic                      hub_r1 = 1'b0, hub_g1 = 1'b0, hub_b1 = 1'b0;
  logic                      hub_r2 = 1'b0, hub_g2 = 1'b0, hub_b2 = 1'b0;
  logic [AW-1:0]             hub_addr = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic [$clog2(W)-1:0]      out_x;
  logic [$clog2(H)-1:0]      out_y;
  logic [2:0]                out_rgb;
  logic                      line_error, drop, blank_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Written only by the monitor.
  beat_t beats[$];
  int    line_cnt = 0, drop_cnt = 0, blank_cnt = 0, stall_viol = 0;

  // Written only by the tests.
  logic [5:0] px[$];
  beat_t      exp_q[$];
  int         ready_mode = 0;   // 0: ready low, 1: ready high, 2: random

  always #5 clock = ~clock;

  hub75_receiver dut (
    .clock       (clock),
    .reset       (reset),
    .hub_clk     (hub_clk),
    .hub_lat     (hub_lat),
    .hub_oe      (hub_oe),
    .hub_r1      (hub_r1),
    .hub_g1      (hub_g1),
    .hub_b1      (hub_b1),
    .hub_r2      (hub_r2),
    .hub_g2      (hub_g2),
    .hub_b2      (hub_b2),
    .hub_addr    (hub_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_rgb     (out_rgb),
    .line_error  (line_error),
    .drop        (drop),
    .blank_error (blank_error)
  );

  // Consumer-side ready driver.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: records accepted beats, counts pulses and checks stall stability.
  logic        stalled = 1'b0;
  beat_t       held;
  always @(negedge clock) begin
    beat_t b;
    if (!reset) begin
      stalled = 1'b0;
    end else begin
      b.x = 32'(out_x); b.y = 32'(out_y); b.rgb = 32'(out_rgb);
      if (stalled && (!out_valid || b !== held)) stall_viol++;
      if (line_error === 1'b1)  line_cnt++;
      if (drop === 1'b1)        drop_cnt++;
      if (blank_error === 1'b1) blank_cnt++;
      if (out_valid && out_ready) beats.push_back(b);
      stalled = out_valid && !out_ready;
      held    = b;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic shift_px(input logic [5:0] p);
    {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = p;
    tick(4);
    hub_clk = 1'b1;
    tick(4);
    hub_clk = 1'b0;
  endtask

  task automatic latch_row(input int addr);
    hub_addr = AW'(addr);
    tick(4);
    hub_lat = 1'b1;
    tick(4);
    hub_lat = 1'b0;
    tick(4);
  endtask

  task automatic shift_all();
    foreach (px[i]) shift_px(px[i]);
  endtask

  task automatic rand_px(input int n);
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(6'($urandom));
  endtask

  // Reference: the pixel shifted at position p lands in column W-1-p; the upper
  // lane streams first on row, then the lower lane on row + H/2.
  task automatic build_expected(input int row);
    beat_t e;
    logic [5:0] p;
    exp_q.delete();
    for (int half = 0; half < 2; half++) begin
      for (int x = 0; x < W; x++) begin
        p     = px[W - 1 - x];
        e.x   = 32'(x);
        e.y   = 32'(row + half * k_half_height);
        e.rgb = (half == 0) ? 32'(p[5:3]) : 32'(p[2:0]);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_beats(input int target, input int budget, output bit ok);
    int c;
    c = 0;
    while (beats.size() < target && c < budget) begin
      tick(1);
      c++;
    end
    ok = (beats.size() >= target);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_x !== '0)         begin n_fail++; $display("FAIL reset_x: got %0d expected 0", out_x); end
    n_checks++; if (out_y !== '0)         begin n_fail++; $display("FAIL reset_y: got %0d expected 0", out_y); end
    n_checks++; if (out_rgb !== 3'b000)   begin n_fail++; $display("FAIL reset_rgb: got %0d expected 0", out_rgb); end
    n_checks++; if (line_error !== 1'b0)  begin n_fail++; $display("FAIL reset_line_error: got %b expected 0", line_error); end
    n_checks++; if (drop !== 1'b0)        begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop); end
    n_checks++; if (blank_error !== 1'b0) begin n_fail++; $display("FAIL reset_blank_error: got %b expected 0", blank_error); end
    reset = 1'b1;
    tick(6);
    n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", out_valid); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_basic_row();
    int b0, l0, d0, k0;
    bit ok;
    b0 = beats.size(); l0 = line_cnt; d0 = drop_cnt; k0 = blank_cnt;
    ready_mode = 1;
    px.delete();
    for (int i = 0; i < W; i++) px.push_back({3'(i % 8), ~3'(i % 8)});
    build_expected(5);
    shift_all();
    latch_row(5);
    wait_beats(b0 + k_pixels_per_latch, 2000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    tick(20);
    n_checks++; if (beats.size() - b0 != k_pixels_per_latch) begin n_fail++; $display("FAIL basic_count: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL basic_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    n_checks++; if (line_cnt != l0)  begin n_fail++; $display("FAIL basic_line_error: got %0d pulses expected 0", line_cnt - l0); end
    n_checks++; if (drop_cnt != d0)  begin n_fail++; $display("FAIL basic_drop: got %0d pulses expected 0", drop_cnt - d0); end
    n_checks++; if (blank_cnt != k0) begin n_fail++; $display("FAIL basic_blank: got %0d pulses expected 0", blank_cnt - k0); end
    $display("basic_row: addr=5 beats=%0d", beats.size() - b0);
  endtask

  task automatic test_stall();
    int b0, s0;
    bit ok;
    b0 = beats.size(); s0 = stall_viol;
    ready_mode = 2;
    px.delete();
    for (int i = 0; i < W; i++) px.push_back({3'(i % 8), ~3'(i % 8)});
    build_expected(5);
    shift_all();
    latch_row(5);
    wait_beats(b0 + k_pixels_per_latch, 3000, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    tick(20);
    ready_mode = 1;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL stall_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    n_checks++; if (stall_viol != s0) begin n_fail++; $display("FAIL stall_stable: got %0d unstable stalled cycles expected 0", stall_viol - s0); end
    $display("stall_row: addr=5 beats=%0d", beats.size() - b0);
  endtask

  task automatic test_line_error();
    int b0, l0, d0, row;
    bit ok;
    ready_mode = 1;
    b0 = beats.size(); l0 = line_cnt; d0 = drop_cnt;
    rand_px(W - 1);
    shift_all();
    latch_row($urandom_range(0, H / 2 - 1));
    tick(30);
    n_checks++; if (line_cnt - l0 != 1)  begin n_fail++; $display("FAIL short_line_error: got %0d pulses expected 1", line_cnt - l0); end
    n_checks++; if (beats.size() != b0)  begin n_fail++; $display("FAIL short_no_beats: got %0d beats expected 0", beats.size() - b0); end
    n_checks++; if (drop_cnt != d0)      begin n_fail++; $display("FAIL short_drop: got %0d pulses expected 0", drop_cnt - d0); end
    rand_px(W + 2);
    shift_all();
    latch_row($urandom_range(0, H / 2 - 1));
    tick(30);
    n_checks++; if (line_cnt - l0 != 2)  begin n_fail++; $display("FAIL long_line_error: got %0d pulses expected 2", line_cnt - l0); end
    n_checks++; if (beats.size() != b0)  begin n_fail++; $display("FAIL long_no_beats: got %0d beats expected 0", beats.size() - b0); end
    row = $urandom_range(0, H / 2 - 1);
    rand_px(W);
    build_expected(row);
    shift_all();
    latch_row(row);
    wait_beats(b0 + k_pixels_per_latch, 2000, ok);
    tick(20);
    n_checks++; if (beats.size() - b0 != k_pixels_per_latch) begin n_fail++; $display("FAIL recover_count: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL recover_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL recover_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    n_checks++; if (line_cnt - l0 != 2) begin n_fail++; $display("FAIL recover_line_error: got %0d pulses expected 2", line_cnt - l0); end
    $display("line_error: short/long lines rejected, addr=%0d beats=%0d", row, beats.size() - b0);
  endtask

  task automatic test_drop();
    int b0, l0, d0, row_a, c;
    bit ok;
    ready_mode = 0;
    b0 = beats.size(); l0 = line_cnt; d0 = drop_cnt;
    row_a = $urandom_range(0, H / 2 - 1);
    rand_px(W);
    build_expected(row_a);
    shift_all();
    latch_row(row_a);
    c = 0;
    while (!out_valid && c < 100) begin tick(1); c++; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drop_first_valid: got %b expected 1", out_valid); end
    rand_px(W);
    shift_all();
    latch_row($urandom_range(0, H / 2 - 1));
    tick(20);
    n_checks++; if (drop_cnt - d0 != 1) begin n_fail++; $display("FAIL drop_pulse: got %0d pulses expected 1", drop_cnt - d0); end
    n_checks++; if (line_cnt != l0)     begin n_fail++; $display("FAIL drop_line_error: got %0d pulses expected 0", line_cnt - l0); end
    n_checks++; if (beats.size() != b0) begin n_fail++; $display("FAIL drop_stalled: got %0d beats expected 0", beats.size() - b0); end
    ready_mode = 1;
    wait_beats(b0 + k_pixels_per_latch, 2000, ok);
    tick(40);
    n_checks++; if (beats.size() - b0 != k_pixels_per_latch) begin n_fail++; $display("FAIL drop_count: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL drop_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL drop_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    $display("drop: addr=%0d beats=%0d drops=%0d", row_a, beats.size() - b0, drop_cnt - d0);
  endtask

  task automatic test_reset_mid_emit();
    int b0, c, held_cnt, row;
    bit ok;
    ready_mode = 1;
    b0 = beats.size();
    rand_px(W);
    shift_all();
    latch_row($urandom_range(0, H / 2 - 1));
    c = 0;
    while (beats.size() < b0 + 40 && c < 500) begin @(negedge clock); #1; c++; end
    n_checks++; if (beats.size() < b0 + 40) begin n_fail++; $display("FAIL midreset_reach40: got %0d beats expected 40", beats.size() - b0); end
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_x !== '0)       begin n_fail++; $display("FAIL midreset_x: got %0d expected 0", out_x); end
    n_checks++; if (out_y !== '0)       begin n_fail++; $display("FAIL midreset_y: got %0d expected 0", out_y); end
    n_checks++; if (out_rgb !== 3'b000) begin n_fail++; $display("FAIL midreset_rgb: got %0d expected 0", out_rgb); end
    held_cnt = beats.size();
    tick(3);
    reset = 1'b1;
    tick(300);
    n_checks++; if (beats.size() != held_cnt) begin n_fail++; $display("FAIL midreset_quiet: got %0d beats expected 0", beats.size() - held_cnt); end
    b0 = beats.size();
    row = $urandom_range(0, H / 2 - 1);
    rand_px(W);
    build_expected(row);
    shift_all();
    latch_row(row);
    wait_beats(b0 + k_pixels_per_latch, 2000, ok);
    tick(20);
    n_checks++; if (beats.size() - b0 != k_pixels_per_latch) begin n_fail++; $display("FAIL midreset_count: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL midreset_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midreset_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    $display("reset_mid_emit: addr=%0d beats=%0d", row, beats.size() - b0);
  endtask

  task automatic test_blank();
    int b0, k0, row, exp_blank;
    bit ok;
`ifdef HUB75_RX_OE_CHECK_EN
    exp_blank = 1;
`else
    exp_blank = 0;
`endif
    ready_mode = 1;
    b0 = beats.size(); k0 = blank_cnt;
    row = $urandom_range(0, H / 2 - 1);
    rand_px(W);
    build_expected(row);
    shift_all();
    hub_oe = 1'b0;
    tick(4);
    latch_row(row);
    hub_oe = 1'b1;
    wait_beats(b0 + k_pixels_per_latch, 2000, ok);
    tick(20);
    n_checks++; if (blank_cnt - k0 != exp_blank) begin n_fail++; $display("FAIL blank_pulse: got %0d pulses expected %0d", blank_cnt - k0, exp_blank); end
    n_checks++; if (beats.size() - b0 != k_pixels_per_latch) begin n_fail++; $display("FAIL blank_count: got %0d beats expected %0d", beats.size() - b0, k_pixels_per_latch); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (b0 + i >= beats.size()) begin
        n_fail++; $display("FAIL blank_beat[%0d]: got no beat expected x=%0d y=%0d rgb=%0d", i, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end else if (beats[b0 + i] !== exp_q[i]) begin
        n_fail++; $display("FAIL blank_beat[%0d]: got x=%0d y=%0d rgb=%0d expected x=%0d y=%0d rgb=%0d", i,
                           beats[b0 + i].x, beats[b0 + i].y, beats[b0 + i].rgb, exp_q[i].x, exp_q[i].y, exp_q[i].rgb);
      end
    end
    $display("blank: addr=%0d beats=%0d blank_pulses=%0d", row, beats.size() - b0, blank_cnt - k0);
  endtask

  initial begin
    test_reset();
    test_basic_row();
    test_stall();
    test_line_error();
    test_drop();
    test_reset_mid_emit();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_receiver.md
# hub75_receiver

Receive-side endpoint of the HUB-75 panel interface. Samples the panel signals produced by the matrix driver (shift clock, latch, output-enable, two RGB lanes, row address) in the system clock domain. Reassembles each latched row pair into pixels and streams them out with a valid/ready handshake. Serves as a loop-back checker for the driver and as the front end of a panel-chaining/monitor path.

## Interface
- k_width, 64, columns per row (power of two, ≥4)
- k_height, 64, panel rows; address width is $clog2(k_height/2)
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hub_clk  in  1  HUB-75 shift clock (asynchronous to clock)
- hub_lat  in  1  HUB-75 latch
- hub_oe  in  1  HUB-75 output enable, active-low (high = blanked)
- hub_r1, hub_g1, hub_b1  in  1 each  upper-half pixel bits
- hub_r2, hub_g2, hub_b2  in  1 each  lower-half pixel bits
- hub_addr  in  $clog2(k_height/2)  row-pair address
- out_valid  out  1  pixel available
- out_ready  in  1  consumer accepts pixel
- out_x  out  $clog2(k_width)  pixel column
- out_y  out  $clog2(k_height)  pixel row
- out_rgb  out  3  {r,g,b}
- line_error  out  1  one-cycle pulse: latch seen with column count ≠ k_width
- drop  out  1  one-cycle pulse: valid row discarded because output buffer busy
- blank_error  out  1  one-cycle pulse: latch while hub_oe low (only with HUB75_RX_OE_CHECK_EN)

## Operation
- All hub_* inputs pass through 2-flop synchronizers; rising edges of hub_clk and hub_lat are detected on the synchronized values (previous 0, current 1).
- Capture buffer: 2×k_width×3 bits. On each hub_clk rise, the six RGB bits are written at x = k_width-1-col_count (the first shifted pixel reaches the far column); col_count increments and saturates at k_width+1.
- On hub_lat rise:
  - col_count == k_width and FSM in IDLE: copy capture buffer to output buffer, register row = hub_addr, enter EMIT.
  - col_count == k_width and FSM in EMIT: discard the row, pulse drop.
  - col_count ≠ k_width: discard the row, pulse line_error. drop is not also pulsed.
  - col_count is cleared to 0 in every case. The capture buffer is not cleared.
- Simultaneous hub_clk and hub_lat rise in the same cycle: the shift is applied first, then the latch evaluates the updated count.
- FSM states:
  - IDLE: out_valid=0.
  - EMIT: streams 2×k_width pixels. First the upper row, y=row, x=0..k_width-1. Then the lower row, y=row+k_height/2, x=0..k_width-1.
  - After the final accepted pixel, the FSM returns to IDLE.
- Handshake: a transfer occurs when out_valid && out_ready. While out_valid && !out_ready, out_x/out_y/out_rgb are held stable. out_valid never drops before a transfer.
- Capture proceeds during EMIT (double-buffered).
- Reset (asynchronous, any time, including mid-EMIT): FSM→IDLE, col_count=0. Outputs: out_valid=0, out_x=0, out_y=0, out_rgb=0, line_error=0, drop=0, blank_error=0. Synchronizers clear to 0.

## Timing
- Edge-detect latency: a hub input edge is acted on 3 clock cycles after it occurs (2 sync stages + 1 edge register).
- out_valid rises 1 cycle after the latch is acted on. The first pixel is x=0 of the upper row.
- With out_ready held high: one pixel per cycle, 2×k_width cycles per row pair.
- Pulses (line_error, drop, blank_error) are registered and fire in the cycle after the latch is acted on.
- Constraint: hub_clk high and low phases each ≥ 3 clock periods. Faster inputs are undefined.

## Configuration
- HUB75_RX_OE_CHECK_EN defined: on a hub_lat rise with synchronized hub_oe == 0, pulse blank_error. The row is still processed normally.
- HUB75_RX_OE_CHECK_EN undefined: hub_oe is unused and blank_error is tied to 0.

## Structure
- Shared package hub75_pkg holds:
  - typedefs XIndex, YIndex, RowAddr, Rgb (3-bit) and ColCount ($clog2(k_width+2) bits);
  - derived constants k_half_height, k_pixels_per_latch.
- Sub-module hub75_input_sync: parameterized-width 2-flop synchronizer plus rising-edge detector, instantiated for the hub_clk/hub_lat strobes and for the data/address bus.

## Test plan
- Reset, then shift 64 pixels with upper = column index mod 8 and lower = ~upper, then latch with addr=5 → 128 beats. The upper row is y=5, x=0..63, rgb matching the pixel shifted at position 63-x. The lower row is y=37.
- Same row, with out_ready toggled pseudo-randomly → identical beat sequence; outputs stable while stalled.
- Shift 63 pixels then latch → line_error pulses once, no out_valid. Then shift 66 pixels and latch → line_error again. Then shift 64 pixels and latch → normal row.
- Latch a second valid row while the first is mid-EMIT with out_ready=0 → drop pulses once; the first row completes unchanged.
- Assert reset at beat 40 of EMIT → out_valid=0 within the same cycle. After release, no beats until the next valid latch.
- With HUB75_RX_OE_CHECK_EN, latch while hub_oe=0 → blank_error pulses and the row still streams. Without the macro, blank_error stays 0.
